// File: rtl/wb_interconnect_arb_wrr_if.sv
// Arbiter-facing bundle: per-master request/enable/weight in, registered grant out.
// master modport is the requester side, slave modport is the arbiter side.
interface wb_interconnect_arb_wrr_if #(
    parameter int N  = 4,
    parameter int WW = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) ();
    logic [N-1:0]    req_i;
    logic [N-1:0]    en_i;
    logic [N*WW-1:0] weight_i;
    logic [N-1:0]    gnt_o;
    logic [IW-1:0]   gnt_idx_o;
    logic            gnt_valid_o;

    modport master (
        output req_i, en_i, weight_i,
        input  gnt_o, gnt_idx_o, gnt_valid_o
    );

    modport slave (
        input  req_i, en_i, weight_i,
        output gnt_o, gnt_idx_o, gnt_valid_o
    );
endinterface

// File: rtl/wb_interconnect_arb_wrr.sv
// Registered weighted round-robin arbiter for a shared Wishbone bus; grant held for the whole cycle.
// Latency: 1 cycle request->grant and release->idle; owner ignores backpressure from other requesters.
module wb_interconnect_arb_wrr #(
    parameter int N  = 4,
    parameter int WW = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    wb_interconnect_arb_wrr_if.slave  bus
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [WW-1:0]   credit_q, credit_d;

    logic [N-1:0]    elig;
    logic [IW-1:0]   cand;
    logic [IW:0]     probe;
    logic            found;
    logic [WW-1:0]   wsel;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            idx_q       <= IW'(N - 1);
            credit_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            idx_q       <= idx_d;
            credit_q    <= credit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        idx_d       = idx_q;
        credit_d    = credit_q;
        elig        = bus.req_i & bus.en_i;
        cand        = idx_q;
        probe       = '0;
        found       = 1'b0;
        wsel        = '0;

        case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    if (elig[idx_q] && credit_q != '0) begin
                        credit_d = credit_q - WW'(1);
                    end else begin
                        // Search starts one past the last owner and may wrap onto it.
                        for (int k = 1; k <= N; k++) begin
                            probe = {1'b0, idx_q} + (IW+1)'(k);
                            if (probe >= (IW+1)'(N)) begin
                                probe = probe - (IW+1)'(N);
                            end
                            if (!found && elig[probe[IW-1:0]]) begin
                                found = 1'b1;
                                cand  = probe[IW-1:0];
                            end
                        end
                        for (int k = 0; k < N; k++) begin
                            if (cand == IW'(k)) begin
                                wsel = bus.weight_i[k*WW +: WW];
                            end
                        end
                        credit_d = (wsel == '0) ? '0 : wsel - WW'(1);
                    end
                    idx_d       = cand;
                    gnt_d       = N'(1) << cand;
                    gnt_valid_d = 1'b1;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // Enable only gates new grants; the owner keeps the bus until it drops cyc.
                if (!bus.req_i[idx_q]) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_valid_o = gnt_valid_q;
    assign bus.gnt_idx_o   = idx_q;

    grant_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.gnt_valid_o == (|bus.gnt_o)) && $onehot0(bus.gnt_o));

endmodule

// File: tb/tb_wb_interconnect_arb_wrr.sv
// Bench for the weighted round-robin arbiter: table rows of grant sequences checked via a scoreboard,
// plus directed sequences for enable masking and mid-transaction reset.
module tb_wb_interconnect_arb_wrr;

    localparam int N  = 4;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_interconnect_arb_wrr_if #(.N(N), .WW(WW)) bus ();

    wb_interconnect_arb_wrr #(.N(N), .WW(WW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [3:0]  en;
        logic [15:0] weight;
        logic [3:0]  mask0;   // request mask until the first grant appears
        logic [3:0]  mask;    // request mask afterwards
        int          len;     // cycles each owner holds the grant
        int          ngnt;
        int          exp[10];
    } vec_t;

    vec_t vecs[5];
    int   exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int oh2i(input logic [3:0] g);
        int r;
        r = -1;
        for (int k = 0; k < 4; k++) if (g[k]) r = k;
        return r;
    endfunction

    task automatic do_reset(input logic [3:0] en, input logic [15:0] w);
        rst          = 1'b1;
        bus.req_i    = '0;
        bus.en_i     = en;
        bus.weight_i = w;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_gnt", 32'(bus.gnt_o), 32'h0);
        chk("reset_valid", 32'(bus.gnt_valid_o), 32'h0);
        chk("reset_idx", 32'(bus.gnt_idx_o), 32'd3);
    endtask

    task automatic run_row(input vec_t v);
        int         hc[4];
        int         cyc, gap, last_idx, e;
        bit         first;
        logic [3:0] g, prev, base, nreq;

        do_reset(v.en, v.weight);
        for (int i = 0; i < v.ngnt; i++) exp_q.push_back(v.exp[i]);
        for (int k = 0; k < 4; k++) hc[k] = 0;
        cyc = 0; gap = 0; last_idx = 3; first = 1'b1; prev = '0;
        rst       = 1'b0;
        bus.req_i = v.mask0;

        while (exp_q.size() > 0 && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            g = bus.gnt_o;
            chk({v.name, "_valid"}, 32'(bus.gnt_valid_o), 32'(|g));
            if (g != '0 && prev == '0) begin
                e = exp_q.pop_front();
                chk({v.name, "_onehot"}, 32'($onehot(g)), 32'd1);
                chk({v.name, "_owner"}, 32'(oh2i(g)), 32'(e));
                chk({v.name, "_idx"}, 32'(bus.gnt_idx_o), 32'(e));
                if (first) chk({v.name, "_first_latency"}, 32'(cyc), 32'd1);
                else       chk({v.name, "_idle_gap"}, 32'(gap), 32'd1);
                first    = 1'b0;
                last_idx = e;
            end else if (g == '0 && !first) begin
                chk({v.name, "_idx_hold"}, 32'(bus.gnt_idx_o), 32'(last_idx));
            end
            gap = (g == '0) ? gap + 1 : 0;
            base = first ? v.mask0 : v.mask;
            for (int k = 0; k < 4; k++) begin
                hc[k]   = g[k] ? hc[k] + 1 : 0;
                nreq[k] = base[k] && !(g[k] && hc[k] >= v.len);
            end
            bus.req_i = nreq;
            prev = g;
        end
        chk({v.name, "_complete"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"rr_equal",   4'hF, 16'h1111, 4'hF, 4'hF, 2, 5, '{0,1,2,3,0,0,0,0,0,0}};
        vecs[1] = '{"weight3",    4'hF, 16'h1113, 4'hF, 4'hF, 2, 9, '{0,0,0,1,2,3,0,0,0,0}};
        vecs[2] = '{"single_m2",  4'hF, 16'h1111, 4'h4, 4'h4, 3, 3, '{2,2,2,0,0,0,0,0,0,0}};
        vecs[3] = '{"en_mask",    4'hD, 16'h1111, 4'hF, 4'hF, 2, 5, '{0,2,3,0,2,0,0,0,0,0}};
        vecs[4] = '{"weight_zero",4'hF, 16'h0111, 4'h8, 4'hF, 2, 6, '{3,0,1,2,3,0,0,0,0,0}};

        for (int r = 0; r < 5; r++) run_row(vecs[r]);

        // Clearing the owner's enable does not revoke its grant.
        do_reset(4'hF, 16'h1111);
        rst       = 1'b0;
        bus.req_i = 4'b0001;
        @(posedge clk); #1;
        chk("en_drop_grant", 32'(bus.gnt_o), 32'b0001);
        bus.en_i  = 4'b1110;
        bus.req_i = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("en_drop_hold", 32'(bus.gnt_o), 32'b0001);
        end
        bus.req_i = 4'b1110;
        @(posedge clk); #1;
        chk("en_drop_release", 32'(bus.gnt_o), 32'b0000);
        bus.req_i = 4'b1111;
        @(posedge clk); #1;
        chk("en_drop_next", 32'(bus.gnt_o), 32'b0010);

        // Reset while master 2 owns the bus; stale pointer/credit must not survive.
        do_reset(4'hF, 16'h1311);
        rst       = 1'b0;
        bus.req_i = 4'b0100;
        #1;
        chk("no_comb_path", 32'(bus.gnt_o), 32'h0);
        @(posedge clk); #1;
        chk("mid_rst_owner", 32'(bus.gnt_o), 32'b0100);
        chk("mid_rst_owner_idx", 32'(bus.gnt_idx_o), 32'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_gnt", 32'(bus.gnt_o), 32'h0);
        chk("mid_rst_valid", 32'(bus.gnt_valid_o), 32'h0);
        chk("mid_rst_idx", 32'(bus.gnt_idx_o), 32'd3);
        rst       = 1'b0;
        bus.req_i = 4'b0110;
        #1;
        chk("post_rst_no_comb", 32'(bus.gnt_o), 32'h0);
        @(posedge clk); #1;
        chk("post_rst_first", 32'(bus.gnt_o), 32'b0010);
        chk("post_rst_idx", 32'(bus.gnt_idx_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
